// File: rtl/muldiv_pkg.sv
// Shared op and FSM state encodings for the iterative multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MULHU = 2'b01,
      OP_DIVU  = 2'b10,
      OP_REMU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider; wb_valid lands W+1 cycles after accept.
// No backpressure: start is dropped (not queued) while busy, and wb_valid is a one-cycle strobe.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int REG_DATA_WIDTH = 16,
   parameter int REG_ADDR_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                op,
   input  logic [REG_DATA_WIDTH-1:0] rs1_data,
   input  logic [REG_DATA_WIDTH-1:0] rs2_data,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
   output logic                      busy,
   output logic                      wb_valid,
   output logic [REG_ADDR_WIDTH-1:0] wb_addr,
   output logic [REG_DATA_WIDTH-1:0] wb_data
);

   localparam int W     = REG_DATA_WIDTH;
   localparam int CNT_W = $clog2(REG_DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

   state_e              state;
   op_e                 op_q;
   logic [CNT_W-1:0]    cnt;
   logic [2*W-1:0]      acc;
   logic [W-1:0]        opb;
   logic [REG_ADDR_WIDTH-1:0] rd_q;

   logic                is_mul;
   logic [W+1:0]        alu_a;
   logic [W+1:0]        alu_sum;
   logic [2*W-1:0]      acc_next;
   logic [W-1:0]        result;

   assign is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);

   // acc upper half is the product high word or the partial remainder; lower half is multiplier or dividend/quotient.
   always_comb begin
      alu_a    = '0;
      alu_sum  = '0;
      acc_next = acc;
      result   = '0;
      if (is_mul) begin
         alu_a   = {2'b00, acc[2*W-1:W]};
         alu_sum = alu_a + {2'b00, opb};
         if (acc[0]) begin
            acc_next = {alu_sum[W:0], acc[W-1:1]};
         end else begin
            acc_next = {1'b0, acc[2*W-1:W], acc[W-1:1]};
         end
      end else begin
         alu_a   = {1'b0, acc[2*W-1:W], acc[W-1]};
         alu_sum = alu_a - {2'b00, opb};
         // Borrow clear means the trial subtract fits; otherwise keep the shifted remainder.
         if (!alu_sum[W+1]) begin
            acc_next = {alu_sum[W-1:0], acc[W-2:0], 1'b1};
         end else begin
            acc_next = {alu_a[W-1:0], acc[W-2:0], 1'b0};
         end
      end
      // MULHU and REMU take the upper half, MUL and DIVU the lower half.
      result = op_q[0] ? acc_next[2*W-1:W] : acc_next[W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         op_q     <= OP_MUL;
         cnt      <= '0;
         acc      <= '0;
         opb      <= '0;
         rd_q     <= '0;
         busy     <= 1'b0;
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q  <= op_e'(op);
                  opb   <= op[1] ? rs2_data : rs1_data;
                  acc   <= {{W{1'b0}}, (op[1] ? rs1_data : rs2_data)};
                  rd_q  <= rd_addr_in;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  wb_valid <= 1'b1;
                  wb_addr  <= rd_q;
                  wb_data  <= result;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               wb_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               wb_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: randomized and directed ops against an arithmetic reference model.
module tb_muldiv_unit;

   localparam int W  = 16;
   localparam int AW = 4;
   localparam logic [1:0] MUL   = 2'b00;
   localparam logic [1:0] MULHU = 2'b01;
   localparam logic [1:0] DIVU  = 2'b10;
   localparam logic [1:0] REMU  = 2'b11;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  rs1_data;
   logic [W-1:0]  rs2_data;
   logic [AW-1:0] rd_addr_in;
   logic          busy;
   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic [W-1:0]  wb_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
   } wb_t;

   wb_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   muldiv_unit #(.REG_DATA_WIDTH(W), .REG_ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op         (op),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .rd_addr_in (rd_addr_in),
      .busy       (busy),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endfunction

   // Plain-arithmetic reference: full product, integer quotient/remainder, divide-by-zero rules.
   function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint unsigned ua = longint'(a);
      longint unsigned ub = longint'(b);
      longint unsigned p  = ua * ub;
      case (o)
         MUL:     return p[W-1:0];
         MULHU:   return p[2*W-1:W];
         DIVU:    return (ub == 0) ? {W{1'b1}} : W'(ua / ub);
         default: return (ub == 0) ? a : W'(ua % ub);
      endcase
   endfunction

   // Monitor: every writeback strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      wb_t e;
      if (wb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_wb: got addr=%0d data=0x%0h, required no writeback", wb_addr, wb_data);
         end else begin
            e = exp_q.pop_front();
            chk("wb_addr", 64'(wb_addr), 64'(e.addr));
            chk("wb_data", 64'(wb_data), 64'(e.data));
         end
      end
   end

   // Issues one op on the current cycle; returns at the negedge of the writeback cycle.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] rd, input bit poke, output int acc_cyc);
      int lat;
      int busy_cnt;
      start      = 1'b1;
      op         = o;
      rs1_data   = a;
      rs2_data   = b;
      rd_addr_in = rd;
      @(posedge clk);
      acc_cyc = cyc;
      exp_q.push_back('{addr: rd, data: ref_result(o, a, b)});
      #1;
      start      = poke;
      op         = 2'($urandom);
      rs1_data   = W'($urandom);
      rs2_data   = W'($urandom);
      rd_addr_in = AW'($urandom);
      lat      = 0;
      busy_cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy === 1'b1) busy_cnt++;
         if (poke) begin
            start    = 1'b1;
            op       = 2'($urandom);
            rs1_data = W'($urandom);
            rs2_data = W'($urandom);
         end
      end while (wb_valid !== 1'b1 && lat < 40);
      chk("latency", 64'(lat), 64'd17);
      chk("busy_cycles", 64'(busy_cnt), 64'd17);
   endtask

   task automatic op_idle(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [AW-1:0] rd, output int acc_cyc);
      run_op(o, a, b, rd, 1'b0, acc_cyc);
      @(negedge clk);
      chk("busy_idle_after_done", 64'(busy), 64'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int a0;
      int a1;
      int busy_seen;
      logic [1:0]    ro;
      logic [W-1:0]  ra;
      logic [W-1:0]  rb;

      rst        = 1'b1;
      start      = 1'b0;
      op         = 2'b00;
      rs1_data   = '0;
      rs2_data   = '0;
      rd_addr_in = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_wb_valid", 64'(wb_valid), 64'd0);
      chk("reset_wb_addr", 64'(wb_addr), 64'd0);
      chk("reset_wb_data", 64'(wb_data), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      op_idle(MUL, 16'h0003, 16'h0005, 4'd5, a0);
      op_idle(MUL, 16'hFFFF, 16'hFFFF, 4'd1, a0);
      op_idle(MULHU, 16'hFFFF, 16'hFFFF, 4'd2, a0);
      op_idle(DIVU, 16'd100, 16'd7, 4'd3, a0);
      op_idle(REMU, 16'd100, 16'd7, 4'd4, a0);
      op_idle(DIVU, 16'd7, 16'd100, 4'd0, a0);
      op_idle(DIVU, 16'h1234, 16'h0000, 4'd6, a0);
      op_idle(REMU, 16'h1234, 16'h0000, 4'd7, a0);

      // start held high with fresh operands throughout RUN and DONE must be ignored.
      run_op(MULHU, 16'hABCD, 16'h1234, 4'd9, 1'b1, a0);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_poke", 64'(busy), 64'd0);
      busy_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_seen++;
      end
      chk("no_op_from_poke", 64'(busy_seen), 64'd0);
      chk("wb_data_hold", 64'(wb_data), 64'(ref_result(MULHU, 16'hABCD, 16'h1234)));

      // Back-to-back: second start in the idle cycle right after DONE.
      run_op(REMU, 16'hBEEF, 16'h0123, 4'd10, 1'b0, a0);
      @(negedge clk);
      run_op(MUL, 16'h0101, 16'h0003, 4'd11, 1'b0, a1);
      chk("back_to_back_period", 64'(a1 - a0), 64'd18);
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 15));
            2:       rb = ra;
            default: rb = W'($urandom);
         endcase
         op_idle(ro, ra, rb, AW'($urandom), a0);
      end

      op_idle(MUL, 16'h0101, 16'h0003, 4'd7, a0);

      // Async reset after 8 iterations of a DIVU: outputs clear at once, no writeback follows.
      start      = 1'b1;
      op         = DIVU;
      rs1_data   = 16'hF00D;
      rs2_data   = 16'h0013;
      rd_addr_in = 4'd12;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_wb_valid", 64'(wb_valid), 64'd0);
      chk("midrst_wb_data", 64'(wb_data), 64'd0);
      chk("midrst_wb_addr", 64'(wb_addr), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      busy_seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_seen++;
      end
      chk("no_op_after_reset", 64'(busy_seen), 64'd0);
      op_idle(MUL, 16'h0002, 16'h0003, 4'd3, a0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
